// File: rtl/riscv_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant encoding, default widths.
package riscv_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned AW_DEF   = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; last_grant only advances when the caller says a grant was taken.
module rr_arb2
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   update,
  output grant_t grant
);

  grant_t last_grant;

  // On conflict the port opposite to the previous winner is chosen.
  always_comb begin
    grant = GNT_I;
    if (req_i && req_d) begin
      if (last_grant == GNT_I) grant = GNT_D;
      else                     grant = GNT_I;
    end else if (req_d) begin
      grant = GNT_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= GNT_I;
    else if (update) last_grant <= grant;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports:
// one registered transaction at a time, completion reported by a one-cycle valid pulse.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            stall_if,
  output logic            stall_mem
);

  arb_state_t state, state_nxt;
  grant_t     grant;
  logic       arb_update;

  logic            mem_req_nxt;
  logic            mem_we_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic [XLEN-1:0] mem_wdata_nxt;
  logic [XLEN-1:0] if_rdata_nxt;
  logic [XLEN-1:0] dm_rdata_nxt;
  logic            if_valid_nxt;
  logic            dm_valid_nxt;

  // Round-robin history moves only when both ports contend.
  assign arb_update = (state == IDLE) && if_req && dm_req;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req_i  (if_req),
    .req_d  (dm_req),
    .update (arb_update),
    .grant  (grant)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      dm_rdata  <= dm_rdata_nxt;
      if_valid  <= if_valid_nxt;
      dm_valid  <= dm_valid_nxt;
    end
  end

  // Next state; requests are only looked at from IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          if (grant == GNT_D) state_nxt = BUSY_D;
          else                state_nxt = BUSY_I;
        end
      end
      BUSY_I:  if (mem_ready) state_nxt = DONE_I;
      BUSY_D:  if (mem_ready) state_nxt = DONE_D;
      DONE_I:  state_nxt = IDLE;
      DONE_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; mem_* are frozen while a transaction is open.
  always_comb begin
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    if_valid_nxt  = 1'b0;
    dm_valid_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          mem_req_nxt = 1'b1;
          if (grant == GNT_D) begin
            mem_we_nxt    = dm_we;
            mem_addr_nxt  = dm_addr;
            mem_wdata_nxt = dm_wdata;
          end else begin
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = if_addr;
          end
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          mem_req_nxt  = 1'b0;
          if_rdata_nxt = mem_rdata;
          if_valid_nxt = 1'b1;
        end
      end
      BUSY_D: begin
        // Read data is captured on stores too; the requester ignores it.
        if (mem_ready) begin
          mem_req_nxt  = 1'b0;
          dm_rdata_nxt = mem_rdata;
          dm_valid_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.XLEN(32), .AW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
  endtask

  // Leaves the bench 1ns after a posedge with the DUT idle: the caller's first cycle is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    mid();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus got=%0h/%0h exp=0/0", mem_addr, mem_wdata); end
    checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h/%0h exp=0/0", if_valid, dm_valid); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%0h/%0h exp=0/0", if_rdata, dm_rdata); end
    tick();
    rst = 1'b0;
    mid();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_idle_mem_req got=%0h exp=0", mem_req); end
    tick();
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    mid();
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got=%0h exp=1", stall_if); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_mem_req_c0 got=%0h exp=0", mem_req); end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    mid();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req_c1 got=%0h exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_mem_addr got=%0h exp=10", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_we got=%0h exp=0", mem_we); end
    checks++; if (stall_if !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL fetch_c1 stall/valid got=%0h/%0h exp=1/0", stall_if, if_valid); end
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    mid();
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid_c2 got=%0h exp=1", if_valid); end
    checks++; if (if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_rdata got=%0h exp=00500093", if_rdata); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fetch_stall_c2 got=%0h exp=0", stall_if); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_mem_req_c2 got=%0h exp=0", mem_req); end
    tick();
    if_req = 1'b0;
    mid();
    checks++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_c3 valid/mem_req got=%0h/%0h exp=0/0", if_valid, mem_req); end
    checks++; if (if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_rdata_hold got=%0h exp=00500093", if_rdata); end
    tick();
  endtask

  task automatic test_store();
    do_reset();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    tick();
    for (int c = 1; c <= 3; c++) begin
      mem_ready = (c == 3);
      mem_rdata = (c == 3) ? 32'h1234_5678 : 32'h0;
      mid();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL store_c%0d req/we got=%0h/%0h exp=1/1", c, mem_req, mem_we); end
      checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_c%0d addr/wdata got=%0h/%0h exp=100/deadbeef", c, mem_addr, mem_wdata); end
      checks++; if (dm_valid !== 1'b0 || stall_mem !== 1'b1) begin errors++; $display("FAIL store_c%0d valid/stall got=%0h/%0h exp=0/1", c, dm_valid, stall_mem); end
      tick();
    end
    mem_ready = 1'b0; mem_rdata = 32'h0;
    mid();
    checks++; if (dm_valid !== 1'b1) begin errors++; $display("FAIL store_valid_c4 got=%0h exp=1", dm_valid); end
    checks++; if (dm_rdata !== 32'h1234_5678) begin errors++; $display("FAIL store_rdata got=%0h exp=12345678", dm_rdata); end
    checks++; if (mem_req !== 1'b0 || stall_mem !== 1'b0) begin errors++; $display("FAIL store_c4 req/stall got=%0h/%0h exp=0/0", mem_req, stall_mem); end
    tick();
    dm_req = 1'b0; dm_we = 1'b0;
    mid();
    checks++; if (dm_valid !== 1'b0) begin errors++; $display("FAIL store_valid_c5 got=%0h exp=0", dm_valid); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_0001;
    mid();
    checks++; if (mem_req !== 1'b0 || dm_valid !== 1'b0) begin errors++; $display("FAIL sim_c0 req/valid got=%0h/%0h exp=0/0", mem_req, dm_valid); end
    tick();
    mid();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL sim_c1 first grant req/addr got=%0h/%0h exp=1/200", mem_req, mem_addr); end
    tick();
    mem_rdata = 32'hBBBB_0002;
    mid();
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hAAAA_0001) begin errors++; $display("FAIL sim_c2 dm valid/rdata got=%0h/%0h exp=1/aaaa0001", dm_valid, dm_rdata); end
    checks++; if (if_valid !== 1'b0 || stall_if !== 1'b1 || stall_mem !== 1'b0) begin errors++; $display("FAIL sim_c2 if_valid/stall_if/stall_mem got=%0h/%0h/%0h exp=0/1/0", if_valid, stall_if, stall_mem); end
    tick();
    dm_req = 1'b0;
    mid();
    checks++; if (mem_req !== 1'b0 || dm_valid !== 1'b0) begin errors++; $display("FAIL sim_c3 req/valid got=%0h/%0h exp=0/0", mem_req, dm_valid); end
    tick();
    mid();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || mem_we !== 1'b0) begin errors++; $display("FAIL sim_c4 I grant req/addr/we got=%0h/%0h/%0h exp=1/20/0", mem_req, mem_addr, mem_we); end
    tick();
    mid();
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hBBBB_0002) begin errors++; $display("FAIL sim_c5 if valid/rdata got=%0h/%0h exp=1/bbbb0002", if_valid, if_rdata); end
    tick();
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    int run_i;
    int run_d;
    int max_i;
    int max_d;
    logic [31:0] exp_addr;
    run_i = 0; run_d = 0; max_i = 0; max_d = 0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h24;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h240;
    mem_ready = 1'b1; mem_rdata = 32'h7777_0000;
    for (int c = 0; c < 24; c++) begin
      mid();
      if (c % 3 == 1) begin
        exp_addr = (((c / 3) % 2) == 0) ? 32'h240 : 32'h24;
        checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin errors++; $display("FAIL fair_grant_c%0d req/addr got=%0h/%0h exp=1/%0h", c, mem_req, mem_addr, exp_addr); end
      end
      run_i = stall_if ? run_i + 1 : 0;
      run_d = stall_mem ? run_d + 1 : 0;
      if (run_i > max_i) max_i = run_i;
      if (run_d > max_d) max_d = run_d;
      tick();
    end
    checks++; if (max_i > 6) begin errors++; $display("FAIL fair_stall_if_run got=%0d exp<=6", max_i); end
    checks++; if (max_d > 6) begin errors++; $display("FAIL fair_stall_mem_run got=%0d exp<=6", max_d); end
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    tick();
    mid();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_c1 mem_req got=%0h exp=1", mem_req); end
    tick();
    rst = 1'b1; dm_req = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || dm_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rmid_async req/dv/iv got=%0h/%0h/%0h exp=0/0/0", mem_req, dm_valid, if_valid); end
    tick();
    rst = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h9999_9999;
    for (int c = 0; c < 4; c++) begin
      mid();
      checks++; if (mem_req !== 1'b0 || dm_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle_c%0d req/dv/iv got=%0h/%0h/%0h exp=0/0/0", c, mem_req, dm_valid, if_valid); end
      tick();
    end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got=%0h exp=0", dm_rdata); end
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
    tick();
    dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h44;
    mid();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin errors++; $display("FAIL wd_c1 req/addr got=%0h/%0h exp=1/400", mem_req, mem_addr); end
    checks++; if (stall_mem !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL wd_c1 stall_mem/stall_if got=%0h/%0h exp=0/1", stall_mem, stall_if); end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0004;
    mid();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin errors++; $display("FAIL wd_c2 req/addr got=%0h/%0h exp=1/400", mem_req, mem_addr); end
    tick();
    mem_ready = 1'b0;
    mid();
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hCAFE_0004) begin errors++; $display("FAIL wd_c3 valid/rdata got=%0h/%0h exp=1/cafe0004", dm_valid, dm_rdata); end
    checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL wd_c3 req/if_valid got=%0h/%0h exp=0/0", mem_req, if_valid); end
    tick();
    mid();
    checks++; if (dm_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL wd_c4 valid/req got=%0h/%0h exp=0/0", dm_valid, mem_req); end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h5555_0044;
    mid();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b0) begin errors++; $display("FAIL wd_c5 req/addr/we got=%0h/%0h/%0h exp=1/44/0", mem_req, mem_addr, mem_we); end
    tick();
    mem_ready = 1'b0;
    mid();
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h5555_0044 || dm_valid !== 1'b0) begin errors++; $display("FAIL wd_c6 iv/ird/dv got=%0h/%0h/%0h exp=1/55550044/0", if_valid, if_rdata, dm_valid); end
    tick();
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_simultaneous();
    test_fairness();
    test_reset_mid();
    test_withdraw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
